// File: rtl/key_counter_ctrl.sv
// Up/down event counter driven by debounced key flag/state pairs: clear key, saturate-or-wrap,
// ovf/unf pulses, active-low LED drive. Hold-to-auto-repeat is built when KEY_COUNTER_REPEAT_EN is defined.
module key_counter_ctrl #(
    parameter int unsigned WIDTH         = 4,
    parameter bit          SATURATE      = 1'b0,
    parameter int unsigned INIT_VAL      = 0,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic             clk_50mhz,
    input  logic             rst,
    input  logic             key_flag_up,
    input  logic             key_state_up,
    input  logic             key_flag_dn,
    input  logic             key_state_dn,
    input  logic             key_flag_clr,
    input  logic             key_state_clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] leds,
    output logic             ovf,
    output logic             unf
);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] INIT_CNT = WIDTH'(INIT_VAL);

    logic press_up;
    logic press_dn;
    logic press_clr;
    logic rep_tick_c;
    logic rep_dn_c;

    assign press_up  = key_flag_up  & ~key_state_up;
    assign press_dn  = key_flag_dn  & ~key_state_dn;
    assign press_clr = key_flag_clr & ~key_state_clr;

`ifdef KEY_COUNTER_REPEAT_EN
    localparam int unsigned TIMER_W = 32;
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 dir_q;
    logic                 dir_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic                 release_up;
    logic                 release_dn;
    logic                 dir_release;

    assign release_up  = key_flag_up & key_state_up;
    assign release_dn  = key_flag_dn & key_state_dn;
    assign dir_release = dir_q ? release_dn : release_up;

    // Repeat FSM state register; dir_q = 1 means the held key is the down key.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    // Next state: timer/release handling first, then key presses override it.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        case (state_q)
            ST_DELAY, ST_REPEAT: begin
                if (dir_release) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (rep_tick_c) begin
                    state_d = ST_REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: timer_d = '0;
        endcase
        if (press_clr || (press_up && press_dn)) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else if (press_up || press_dn) begin
            state_d = ST_DELAY;
            dir_d   = press_dn;
            timer_d = '0;
        end
    end

    // Repeat tick outputs; a release of the held key in the same cycle suppresses the tick.
    always_comb begin
        rep_tick_c = 1'b0;
        rep_dn_c   = dir_q;
        if (!dir_release) begin
            case (state_q)
                ST_DELAY:  rep_tick_c = (timer_q == DELAY_LAST);
                ST_REPEAT: rep_tick_c = (timer_q == PERIOD_LAST);
                default:   rep_tick_c = 1'b0;
            endcase
        end
    end
`else
    assign rep_tick_c = 1'b0;
    assign rep_dn_c   = 1'b0;
`endif

    logic             do_up;
    logic             do_dn;
    logic             do_clr;
    logic [WIDTH-1:0] count_d;
    logic             ovf_d;
    logic             unf_d;

    // Event priority: clear > both directions > single press > repeat tick.
    always_comb begin
        do_up  = 1'b0;
        do_dn  = 1'b0;
        do_clr = 1'b0;
        if (press_clr) begin
            do_clr = 1'b1;
        end else if (press_up && press_dn) begin
            do_clr = 1'b0;
        end else if (press_up) begin
            do_up = 1'b1;
        end else if (press_dn) begin
            do_dn = 1'b1;
        end else if (rep_tick_c) begin
            do_dn = rep_dn_c;
            do_up = ~rep_dn_c;
        end
    end

    always_comb begin
        count_d = count;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (do_clr) begin
            count_d = INIT_CNT;
        end else if (do_up) begin
            ovf_d   = (count == MAX_VAL);
            count_d = (ovf_d && SATURATE) ? count : count + WIDTH'(1);
        end else if (do_dn) begin
            unf_d   = (count == '0);
            count_d = (unf_d && SATURATE) ? count : count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            count <= INIT_CNT;
            leds  <= ~INIT_CNT;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_d;
            leds  <= ~count_d;
            ovf   <= ovf_d;
            unf   <= unf_d;
        end
    end
endmodule
